// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-cycle-latency memory interface,
// single-entry skid buffer for stalls, and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_INSTR,
  output logic        IFID_VALID,
  output logic        MISALIGN
);

  // Force a redirect address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [31:0] pc_q,         pc_d;
  logic [31:0] pend_pc_q,    pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] ifid_pc_q,    ifid_pc_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        misalign_q,   misalign_d;

  // Next-state selection: redirect beats stall, stall beats normal advance.
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    hold_instr_d = hold_instr_q;
    hold_valid_d = hold_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = 1'b0;

    if (BRANCH_TAKEN) begin
      pc_d         = word_align(BRANCH_TARGET);
      pend_valid_d = 1'b0;
      hold_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      misalign_d   = (BRANCH_TARGET[1:0] != 2'b00);
    end else if (STALL) begin
      // Memory data for pend_pc arrives only once; park it before the address moves on.
      if (!hold_valid_q && pend_valid_q) begin
        hold_instr_d = IMEM_RDATA;
        hold_valid_d = 1'b1;
      end else begin
        hold_instr_d = hold_instr_q;
        hold_valid_d = hold_valid_q;
      end
    end else begin
      ifid_pc_d    = pend_pc_q;
      ifid_pc4_d   = pend_pc_q + 32'd4;
      ifid_valid_d = pend_valid_q;
      if (!pend_valid_q) begin
        ifid_instr_d = NOP_INSTR;
      end else if (hold_valid_q) begin
        ifid_instr_d = hold_instr_q;
      end else begin
        ifid_instr_d = IMEM_RDATA;
      end
      pend_pc_d    = pc_q;
      pend_valid_d = 1'b1;
      pc_d         = pc_q + 32'd4;
      hold_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q         <= RESET_VECTOR;
      pend_pc_q    <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_valid_q <= hold_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign IMEM_ADDR  = pc_q;
  assign IFID_PC    = ifid_pc_q;
  assign IFID_PC4   = ifid_pc4_q;
  assign IFID_INSTR = ifid_instr_q;
  assign IFID_VALID = ifid_valid_q;
  assign MISALIGN   = misalign_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), meaning the bubble instruction.
REQ-003 SHALL have port CLK, input, 1, clock; all state changes on rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port STALL, input, 1, freezes the PC and the IF/ID outputs.
REQ-006 SHALL have port BRANCH_TAKEN, input, 1, redirects fetch.
REQ-007 SHALL have port BRANCH_TARGET, input, 32, redirect address.
REQ-008 SHALL have port IMEM_ADDR, output, 32, fetch address to instruction memory; equal to pc_q.
REQ-009 SHALL have port IMEM_RDATA, input, 32, instruction word returned one clock after its address is presented.
REQ-010 SHALL have port IFID_PC, output, 32, PC of the registered instruction.
REQ-011 SHALL have port IFID_PC4, output, 32, IFID_PC+4.
REQ-012 SHALL have port IFID_INSTR, output, 32, registered instruction.
REQ-013 SHALL have port IFID_VALID, output, 1, 1 when IFID_INSTR is a real fetched instruction.
REQ-014 SHALL have port MISALIGN, output, 1, one-cycle pulse flagging a redirect target with bits [1:0] not equal to 00.

Function
REQ-015 SHALL hold this internal state: pc_q (issued address), pend_pc/pend_valid (address whose data returns this cycle), hold_instr/hold_valid (skid buffer), plus the IF/ID register.
REQ-016 SHALL, on a normal edge (no RESET, no BRANCH_TAKEN, no STALL), load the IF/ID register as PC=pend_pc, PC4=pend_pc+4, INSTR=(hold_valid ? hold_instr : IMEM_RDATA), VALID=pend_valid.
REQ-017 SHALL, on the same normal edge, update pend_pc<=pc_q, pend_valid<=1, pc_q<=pc_q+4, and hold_valid<=0.
REQ-018 SHALL, on a STALL edge (no BRANCH_TAKEN), hold pc_q, pend_* and the IF/ID register unchanged.
REQ-019 SHALL, on a STALL edge with hold_valid=0 and pend_valid=1, capture IMEM_RDATA into hold_instr and set hold_valid=1; later stall edges SHALL not overwrite hold_instr.
REQ-020 SHALL, on a BRANCH_TAKEN edge, set pc_q<={BRANCH_TARGET[31:2],2'b00}, pend_valid<=0, hold_valid<=0, IFID_VALID<=0 and IFID_INSTR<=NOP_INSTR.
REQ-021 SHALL give BRANCH_TAKEN priority over STALL.
REQ-022 SHALL produce two bubbles after a redirect and present the target instruction with IFID_VALID=1 on the second edge after the redirect edge when unstalled.
REQ-023 SHALL register MISALIGN as 1 for exactly the edge following a BRANCH_TAKEN edge with BRANCH_TARGET[1:0]!=0, and 0 otherwise.
REQ-024 SHALL compute pc_q+4 and pend_pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000, no flag).
REQ-025 SHALL output IFID_INSTR=NOP_INSTR whenever pend_valid=0 is shifted in.
REQ-026 SHALL present the first valid instruction (PC=RESET_VECTOR) on the second rising edge after RESET deasserts, absent STALL.

Reset
REQ-027 SHALL, while RESET=1, immediately and asynchronously set pc_q=RESET_VECTOR, pend_valid=0, hold_valid=0, IFID_PC=0, IFID_PC4=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0, MISALIGN=0.
REQ-028 SHALL let RESET override STALL and BRANCH_TAKEN, including mid-stall and mid-redirect.

Verification
REQ-029 SHALL cover sequential fetch: mem[0]=0x00100293, mem[1]=0x00300313, release reset -> edge 2: IFID_PC=0, INSTR=0x00100293, VALID=1; edge 3: IFID_PC=4, INSTR=0x00300313.
REQ-030 SHALL cover a stall: STALL=1 for 3 cycles while IFID_PC=4 -> outputs held; after release, next edges give IFID_PC=8 then 0xC with mem[2], mem[3] (no skip, no duplicate).
REQ-031 SHALL cover a redirect: BRANCH_TAKEN with target 0x40 while IFID_PC=8 -> two edges of VALID=0 with INSTR=0x00000013, then IFID_PC=0x40, VALID=1.
REQ-032 SHALL cover redirect with stall: BRANCH_TAKEN=1 and STALL=1 together, target 0x80 -> redirect taken, skid cleared, IFID_PC=0x80 valid two edges later (STALL then low).
REQ-033 SHALL cover a misaligned target: target 0x42 -> IMEM_ADDR=0x40, MISALIGN=1 for one cycle.
REQ-034 SHALL cover async reset: RESET asserted between edges during a stall -> outputs reach reset values before the next edge, and the REQ-029 sequence restarts.
